// File: rtl/cnt_down_timer_if.sv
// Control/status bundle for the loadable down-counting timer.
// master drives the controls, slave is the timer itself.
interface cnt_down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output load, load_val, start, pause,
        input  cnt, busy, done, state
    );

    modport slave (
        input  load, load_val, start, pause,
        output cnt, busy, done, state
    );
endinterface

// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer with start/pause/load-abort and done pulse.
// Optional macro CNT_AUTO_RELOAD_EN: loop reload..1 forever instead of single-shot.
module cnt_down_timer #(
    parameter int WIDTH        = 4,
    parameter int DEFAULT_LOAD = 10
) (
    input logic           clk,
    input logic           rst_n,
    cnt_down_timer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] DEF_VAL = WIDTH'(DEFAULT_LOAD);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] eff_val;
    logic             at_one;

    // A zero load value means "use the default period".
    assign eff_val = (bus.load_val == '0) ? DEF_VAL : bus.load_val;
    assign at_one  = (cnt_q <= ONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; load overrides everything, then pause, then start/count.
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = bus.start ? S_RUN : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (bus.start) state_d = S_RUN;
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_PAUSE;
                    end else if (at_one) begin
`ifdef CNT_AUTO_RELOAD_EN
                        state_d = S_RUN;
`else
                        state_d = S_DONE;
`endif
                    end
                end
                S_PAUSE: if (!bus.pause) state_d = S_RUN;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: count, reload register and done pulse.
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.load) begin
            cnt_d    = eff_val;
            reload_d = eff_val;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (!bus.pause) begin
                        if (!at_one) begin
                            cnt_d = cnt_q - ONE;
                        end else begin
                            done_d = 1'b1;
`ifdef CNT_AUTO_RELOAD_EN
                            cnt_d  = reload_q;
`endif
                        end
                    end
                end
                S_DONE:  cnt_d = reload_q;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= DEF_VAL;
            reload_q <= DEF_VAL;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign bus.cnt   = cnt_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
endmodule
